commit_trace_buffer: RTL and testbench

Parametrised commit-trace capture buffer for the pipelined MIPS core. It takes up to CH retirement events per cycle (GRF write, DM write, PC redirect) from the writeback/memory stages and filters out writes to $0. It keeps the events in program order in a DEPTH-entry circular buffer and drains them through a valid/ready port to the testbench logger or an on-chip trace sink. Overflow is handled by a build-time mode, either drop-newest or overwrite-oldest, and lost events are counted.

---
 rtl/commit_trace_buffer_pkg.sv | 22 ++
 rtl/trace_ring_mem.sv | 30 +++
 rtl/commit_trace_buffer.sv | 158 +++++++++++++++
 tb/tb_commit_trace_buffer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_trace_buffer_pkg.sv
// Shared definitions for the commit-trace capture buffer: event kind codes,
// the packed entry layout and the $0-write filter predicate.
package commit_trace_buffer_pkg;

  localparam logic [1:0] TR_GRF = 2'd0;
  localparam logic [1:0] TR_DM  = 2'd1;
  localparam logic [1:0] TR_PC  = 2'd2;
  localparam int         TR_W   = 98;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_entry_t;

  // A GRF write targeting $0 has no architectural effect and is never traced.
  function automatic logic is_zero_grf(input logic [1:0] kind, input logic [4:0] reg_num);
    return (kind == TR_GRF) && (reg_num == 5'd0);
  endfunction

endpackage

// File: rtl/trace_ring_mem.sv
// Storage array for the trace ring: CH independent write ports and one
// asynchronous read port. The array itself is never reset.
module trace_ring_mem #(
  parameter int DEPTH = 16,
  parameter int CH    = 2,
  parameter int W     = 98,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic [CH-1:0]         we_i,
  input  logic [CH-1:0][PW-1:0] widx_i,
  input  logic [CH-1:0][W-1:0]  wdata_i,
  input  logic [PW-1:0]         ridx_i,
  output logic [W-1:0]          rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Compacted write offsets are distinct, so ports never collide on an index.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (we_i[i]) begin
        mem_q[widx_i[i]] <= wdata_i[i];
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-trace capture buffer: filters $0 writes, compacts up to CH events per
// cycle into a circular buffer in program order and drains it via valid/ready.
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CH        = 2,
  parameter int OVERWRITE = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [CH-1:0]           in_valid,
  input  logic [2*CH-1:0]         in_kind,
  input  logic [32*CH-1:0]        in_pc,
  input  logic [32*CH-1:0]        in_addr,
  input  logic [32*CH-1:0]        in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_kind,
  output logic [31:0]             out_pc,
  output logic [31:0]             out_addr,
  output logic [31:0]             out_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic [15:0]             drop_cnt,
  output logic                    overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   drop_q, drop_d;
  logic          ovf_q, ovf_d;

  logic [CH-1:0]          surv_s;
  logic [CH-1:0][CW-1:0]  offs_s;
  logic [CW-1:0]          n_s, free_s, written_s, excess_s, lost_s;
  logic [16:0]            drop_sum_s;
  logic                   pop_s;
  logic [CH-1:0]          we_s;
  logic [CH-1:0][PW-1:0]  widx_s;
  logic [CH-1:0][TR_W-1:0] wdata_s;
  logic [TR_W-1:0]        rdata_s;
  trace_entry_t           head_s;

  assign out_valid = (count_q != '0);
  assign pop_s     = out_valid && out_ready && !flush;

  // Prefix count of surviving channels gives each one its slot offset from the tail.
  always_comb begin
    logic [CW-1:0] run;
    run    = '0;
    surv_s = '0;
    offs_s = '0;
    for (int i = 0; i < CH; i++) begin
      surv_s[i] = in_valid[i] && !is_zero_grf(in_kind[2*i +: 2], in_addr[32*i +: 5]);
      offs_s[i] = run;
      run       = run + CW'(surv_s[i]);
    end
    n_s = run;
  end

  // Space accounting: drop mode truncates the newest events, overwrite mode evicts the oldest.
  always_comb begin
    free_s    = DEPTH_C - count_q + CW'(pop_s);
    written_s = n_s;
    excess_s  = '0;
    lost_s    = '0;
    if (OVERWRITE != 0) begin
      if (n_s > free_s) begin
        excess_s = n_s - free_s;
      end else begin
        excess_s = '0;
      end
      lost_s = excess_s;
    end else begin
      if (n_s > free_s) begin
        written_s = free_s;
      end else begin
        written_s = n_s;
      end
      lost_s = n_s - written_s;
    end
  end

  // Per-channel write ports into the ring.
  always_comb begin
    we_s    = '0;
    widx_s  = '0;
    wdata_s = '0;
    for (int i = 0; i < CH; i++) begin
      we_s[i]    = surv_s[i] && (offs_s[i] < written_s) && !flush;
      widx_s[i]  = tail_q + offs_s[i][PW-1:0];
      wdata_s[i] = {in_kind[2*i +: 2], in_pc[32*i +: 32], in_addr[32*i +: 32], in_data[32*i +: 32]};
    end
  end

  // Pointer, occupancy and loss-counter next state.
  always_comb begin
    drop_sum_s = {1'b0, drop_q} + 17'(lost_s);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      drop_d  = drop_q;
      ovf_d   = ovf_q;
    end else begin
      head_d  = head_q + PW'(pop_s) + excess_s[PW-1:0];
      tail_d  = tail_q + written_s[PW-1:0];
      count_d = count_q - CW'(pop_s) - excess_s + written_s;
      drop_d  = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
      ovf_d   = ovf_q || (lost_s != '0);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= 16'd0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  trace_ring_mem #(
    .DEPTH (DEPTH),
    .CH    (CH),
    .W     (TR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (we_s),
    .widx_i  (widx_s),
    .wdata_i (wdata_s),
    .ridx_i  (head_q),
    .rdata_o (rdata_s)
  );

  assign head_s   = trace_entry_t'(rdata_s);
  assign out_kind = head_s.kind;
  assign out_pc   = head_s.pc;
  assign out_addr = head_s.addr;
  assign out_data = head_s.data;
  assign count    = count_q;
  assign drop_cnt = drop_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: one drop-mode and one
// overwrite-mode instance share stimulus and are tracked by queue scoreboards.
module tb_commit_trace_buffer;

  localparam int DEPTH = 16;
  localparam int CH    = 2;
  localparam logic [1:0] K_GRF = 2'd0;
  localparam logic [1:0] K_DM  = 2'd1;
  localparam logic [1:0] K_PC  = 2'd2;

  logic clk = 1'b0;
  logic reset, flush, out_ready;
  logic [CH-1:0]    in_valid;
  logic [2*CH-1:0]  in_kind;
  logic [32*CH-1:0] in_pc, in_addr, in_data;

  logic        d_valid, o_valid, d_ovf, o_ovf;
  logic [1:0]  d_kind, o_kind;
  logic [31:0] d_pc, d_addr, d_data, o_pc, o_addr, o_data;
  logic [4:0]  d_count, o_count;
  logic [15:0] d_drop, o_drop;

  int n_checks = 0;
  int n_fail   = 0;

  logic [97:0] dq[$];
  logic [97:0] oq[$];
  int   dd = 0;
  int   od = 0;
  logic dovf = 1'b0;
  logic oovf = 1'b0;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(DEPTH), .CH(CH), .OVERWRITE(0)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_kind(in_kind), .in_pc(in_pc), .in_addr(in_addr), .in_data(in_data),
    .out_valid(d_valid), .out_ready(out_ready),
    .out_kind(d_kind), .out_pc(d_pc), .out_addr(d_addr), .out_data(d_data),
    .count(d_count), .drop_cnt(d_drop), .overflow(d_ovf)
  );

  commit_trace_buffer #(.DEPTH(DEPTH), .CH(CH), .OVERWRITE(1)) dut_ow (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_kind(in_kind), .in_pc(in_pc), .in_addr(in_addr), .in_data(in_data),
    .out_valid(o_valid), .out_ready(out_ready),
    .out_kind(o_kind), .out_pc(o_pc), .out_addr(o_addr), .out_data(o_data),
    .count(o_count), .drop_cnt(o_drop), .overflow(o_ovf)
  );

  // Reference model: sequential queue behaviour on every rising edge.
  task automatic model_step();
    logic [97:0] e;
    if (reset) begin
      dq.delete(); oq.delete();
      dd = 0; od = 0; dovf = 1'b0; oovf = 1'b0;
    end else if (flush) begin
      dq.delete(); oq.delete();
    end else begin
      if (dq.size() > 0 && out_ready) void'(dq.pop_front());
      if (oq.size() > 0 && out_ready) void'(oq.pop_front());
      for (int i = 0; i < CH; i++) begin
        if (in_valid[i] && !(in_kind[2*i +: 2] == K_GRF && in_addr[32*i +: 5] == 5'd0)) begin
          e = {in_kind[2*i +: 2], in_pc[32*i +: 32], in_addr[32*i +: 32], in_data[32*i +: 32]};
          if (dq.size() < DEPTH) dq.push_back(e);
          else begin
            if (dd < 65535) dd++;
            dovf = 1'b1;
          end
          oq.push_back(e);
          if (oq.size() > DEPTH) begin
            void'(oq.pop_front());
            if (od < 65535) od++;
            oovf = 1'b1;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // Scoreboard monitor: compare DUT state with model between edges.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      n_checks++;
      if (d_valid !== (dq.size() > 0)) begin n_fail++; $display("FAIL sb_drop_valid: got %b want %0d", d_valid, dq.size() > 0); end
      if (dq.size() > 0) begin
        n_checks++;
        if ({d_kind, d_pc, d_addr, d_data} !== dq[0]) begin
          n_fail++; $display("FAIL sb_drop_head: got addr %h data %h want %h", d_addr, d_data, dq[0]);
        end
      end
      n_checks++;
      if (d_count !== 5'(dq.size()) || d_drop !== 16'(dd) || d_ovf !== dovf) begin
        n_fail++; $display("FAIL sb_drop_status: got cnt %0d drop %0d ovf %b want %0d %0d %b", d_count, d_drop, d_ovf, dq.size(), dd, dovf);
      end
      n_checks++;
      if (o_valid !== (oq.size() > 0)) begin n_fail++; $display("FAIL sb_ow_valid: got %b want %0d", o_valid, oq.size() > 0); end
      if (oq.size() > 0) begin
        n_checks++;
        if ({o_kind, o_pc, o_addr, o_data} !== oq[0]) begin
          n_fail++; $display("FAIL sb_ow_head: got addr %h data %h want %h", o_addr, o_data, oq[0]);
        end
      end
      n_checks++;
      if (o_count !== 5'(oq.size()) || o_drop !== 16'(od) || o_ovf !== oovf) begin
        n_fail++; $display("FAIL sb_ow_status: got cnt %0d drop %0d ovf %b want %0d %0d %b", o_count, o_drop, o_ovf, oq.size(), od, oovf);
      end
    end
  end

  task automatic set_ch(input int i, input logic [1:0] k, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] d);
    in_valid[i]        = 1'b1;
    in_kind[2*i +: 2]  = k;
    in_pc[32*i +: 32]  = pc;
    in_addr[32*i +: 32] = a;
    in_data[32*i +: 32] = d;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = '0;
    for (int c = 0; c < 40 && (dq.size() > 0 || oq.size() > 0); c++) @(negedge clk);
    n_checks++;
    if (dq.size() != 0 || oq.size() != 0 || d_valid !== 1'b0 || o_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain: got valid %b/%b want 0/0 within budget", d_valid, o_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (d_valid !== 1'b0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b/%b want 0/0", d_valid, o_valid); end
    n_checks++;
    if (d_count !== 5'd0 || o_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d/%0d want 0/0", d_count, o_count); end
    n_checks++;
    if (d_drop !== 16'd0 || d_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %0d ovf %b want 0 0", d_drop, d_ovf); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_order();
    logic [31:0] seq[$];
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      in_valid = '0;
      if (c < 5) begin
        set_ch(0, K_GRF, 32'h400 + 32'(8*c), 32'(2*c + 1), 32'hA000 + 32'(c));
        set_ch(1, K_GRF, 32'h404 + 32'(8*c), 32'(2*c + 2), 32'hB000 + 32'(c));
      end
      @(negedge clk);
      if (c == 0) begin
        n_checks++;
        if (d_valid !== 1'b1) begin n_fail++; $display("FAIL order_latency: got valid %b want 1", d_valid); end
      end
      if (d_valid) seq.push_back(d_addr);
    end
    in_valid = '0;
    n_checks++;
    if (seq.size() != 10) begin n_fail++; $display("FAIL order_len: got %0d want 10", seq.size()); end
    for (int i = 0; i < 10 && i < seq.size(); i++) begin
      n_checks++;
      if (seq[i] !== 32'(i + 1)) begin n_fail++; $display("FAIL order_addr[%0d]: got %0d want %0d", i, seq[i], i + 1); end
    end
    n_checks++;
    if (d_drop !== 16'd0) begin n_fail++; $display("FAIL order_drop: got %0d want 0", d_drop); end
    out_ready = 1'b0;
  endtask

  task automatic test_filter();
    out_ready = 1'b0;
    set_ch(0, K_GRF, 32'h500, 32'h0, 32'h1234);
    set_ch(1, K_DM, 32'h504, 32'h40, 32'hBEEF);
    @(negedge clk);
    in_valid = '0;
    n_checks++;
    if (d_count !== 5'd1 || o_count !== 5'd1) begin n_fail++; $display("FAIL filter_count: got %0d/%0d want 1/1", d_count, o_count); end
    n_checks++;
    if (d_kind !== K_DM || d_addr !== 32'h40) begin n_fail++; $display("FAIL filter_head: got kind %0d addr %h want 1 40", d_kind, d_addr); end
    n_checks++;
    if (d_drop !== 16'd0 || d_ovf !== 1'b0) begin n_fail++; $display("FAIL filter_drop: got %0d ovf %b want 0 0", d_drop, d_ovf); end
    drain();
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int c = 0; c < 9; c++) begin
      set_ch(0, K_GRF, 32'h600 + 32'(8*c), 32'(2*c + 1), 32'hC000 + 32'(c));
      set_ch(1, K_GRF, 32'h604 + 32'(8*c), 32'(2*c + 2), 32'hD000 + 32'(c));
      @(negedge clk);
    end
    in_valid = '0;
    n_checks++;
    if (d_count !== 5'd16 || d_drop !== 16'd2 || d_ovf !== 1'b1) begin
      n_fail++; $display("FAIL drop_mode: got cnt %0d drop %0d ovf %b want 16 2 1", d_count, d_drop, d_ovf);
    end
    n_checks++;
    if (d_addr !== 32'd1) begin n_fail++; $display("FAIL drop_head: got %0d want 1", d_addr); end
    n_checks++;
    if (o_count !== 5'd16 || o_drop !== 16'd2 || o_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ow_mode: got cnt %0d drop %0d ovf %b want 16 2 1", o_count, o_drop, o_ovf);
    end
    n_checks++;
    if (o_addr !== 32'd3) begin n_fail++; $display("FAIL ow_head: got %0d want 3", o_addr); end
  endtask

  task automatic test_full_pop();
    logic [31:0] seq[$];
    out_ready = 1'b1;
    set_ch(0, K_PC, 32'h700, 32'h100, 32'd1);
    @(negedge clk);
    in_valid = '0;
    n_checks++;
    if (d_count !== 5'd16 || d_drop !== 16'd2) begin n_fail++; $display("FAIL full_pop_drop: got cnt %0d drop %0d want 16 2", d_count, d_drop); end
    n_checks++;
    if (d_addr !== 32'd2 || o_addr !== 32'd4) begin n_fail++; $display("FAIL full_pop_head: got %0d/%0d want 2/4", d_addr, o_addr); end
    n_checks++;
    if (o_count !== 5'd16 || o_drop !== 16'd2) begin n_fail++; $display("FAIL full_pop_ow: got cnt %0d drop %0d want 16 2", o_count, o_drop); end
    for (int c = 0; c < 20; c++) begin
      if (o_valid) seq.push_back(o_addr);
      @(negedge clk);
    end
    n_checks++;
    if (seq.size() != 16) begin
      n_fail++; $display("FAIL ow_tail_len: got %0d want 16", seq.size());
    end else begin
      n_checks++;
      if (seq[14] !== 32'd18 || seq[15] !== 32'h100) begin
        n_fail++; $display("FAIL ow_tail: got %h %h want 12 100", seq[14], seq[15]);
      end
    end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = '0;
      set_ch(0, K_DM, 32'h800 + 32'(c), 32'h41 + 32'(2*c), 32'hE000 + 32'(c));
      if (c < 3) set_ch(1, K_DM, 32'h880 + 32'(c), 32'h42 + 32'(2*c), 32'hF000 + 32'(c));
      @(negedge clk);
    end
    in_valid = '0;
    n_checks++;
    if (d_count !== 5'd7 || o_count !== 5'd7) begin n_fail++; $display("FAIL flush_pre: got %0d/%0d want 7/7", d_count, o_count); end
    flush = 1'b1;
    out_ready = 1'b1;
    set_ch(0, K_DM, 32'h900, 32'h51, 32'h1);
    set_ch(1, K_DM, 32'h904, 32'h52, 32'h2);
    @(negedge clk);
    flush = 1'b0;
    in_valid = '0;
    out_ready = 1'b0;
    n_checks++;
    if (d_count !== 5'd0 || o_count !== 5'd0 || d_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_count: got %0d/%0d valid %b want 0/0 0", d_count, o_count, d_valid);
    end
    n_checks++;
    if (d_drop !== 16'd2 || d_ovf !== 1'b1 || o_drop !== 16'd2) begin
      n_fail++; $display("FAIL flush_keep: got drop %0d ovf %b ow %0d want 2 1 2", d_drop, d_ovf, o_drop);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_ch(0, K_DM, 32'hA00 + 32'(c), 32'h61 + 32'(c), 32'h11 + 32'(c));
      set_ch(1, K_GRF, 32'hA80 + 32'(c), 32'h3 + 32'(c), 32'h22 + 32'(c));
      @(negedge clk);
    end
    in_valid = '0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (d_valid !== 1'b0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b/%b want 0/0", d_valid, o_valid); end
    n_checks++;
    if (d_drop !== 16'd0 || o_drop !== 16'd0 || d_ovf !== 1'b0) begin
      n_fail++; $display("FAIL async_drop: got %0d/%0d ovf %b want 0/0 0", d_drop, o_drop, d_ovf);
    end
    n_checks++;
    if (d_count !== 5'd0) begin n_fail++; $display("FAIL async_count: got %0d want 0", d_count); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (d_valid !== 1'b0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL async_release: got %b/%b want 0/0", d_valid, o_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int c = 0; c < 400; c++) begin
      in_valid = '0;
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(3, 0) != 0) begin
          a = $urandom;
          if ($urandom_range(3, 0) == 0) a[4:0] = 5'd0;
          set_ch(i, 2'($urandom_range(2, 0)), $urandom, a, $urandom);
        end
      end
      out_ready = (c < 200) ? ($urandom_range(3, 0) != 0) : ($urandom_range(2, 0) == 0);
      flush = ($urandom_range(63, 0) == 0);
      @(negedge clk);
    end
    flush = 1'b0;
    drain();
    n_checks++;
    if (d_count !== 5'd0 || o_count !== 5'd0) begin n_fail++; $display("FAIL b2b_empty: got %0d/%0d want 0/0", d_count, o_count); end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    in_valid = '0;
    in_kind = '0;
    in_pc = '0;
    in_addr = '0;
    in_data = '0;
    test_reset();
    test_order();
    test_filter();
    test_overflow();
    test_full_pop();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
